// File: rtl/mem_wb_pipe.sv
// MEM/WB pipeline register: NUM_CH GPR write channels, optional HI/LO, LLbit,
// with flush / bubble / hold control, per-entry valid bit and a retire counter.
module mem_wb_pipe #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 5,
    parameter int NUM_CH    = 1,
    parameter int HILO_EN   = 1,
    parameter int STAGE_IDX = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [5:0]               stall,
    input  logic                     flush,
    input  logic                     mem_valid,
    input  logic [NUM_CH*ADDR_W-1:0] mem_wd,
    input  logic [NUM_CH-1:0]        mem_wreg,
    input  logic [NUM_CH*DATA_W-1:0] mem_wdata,
    input  logic                     mem_whilo,
    input  logic [DATA_W-1:0]        mem_hi,
    input  logic [DATA_W-1:0]        mem_lo,
    input  logic                     mem_llbit_we,
    input  logic                     mem_llbit_value,
    output logic                     wb_valid,
    output logic [NUM_CH*ADDR_W-1:0] wb_wd,
    output logic [NUM_CH-1:0]        wb_wreg,
    output logic [NUM_CH*DATA_W-1:0] wb_wdata,
    output logic                     wb_whilo,
    output logic [DATA_W-1:0]        wb_hi,
    output logic [DATA_W-1:0]        wb_lo,
    output logic                     wb_llbit_we,
    output logic                     wb_llbit_value,
    output logic [31:0]              retire_cnt
);

    typedef enum logic [1:0] {
        ACT_LOAD,
        ACT_HOLD,
        ACT_BUBBLE,
        ACT_FLUSH
    } action_e;

    action_e                     w_action;
    logic                        w_take;
    logic [NUM_CH-1:0]           w_wreg_base;
    logic [NUM_CH-1:0]           w_wreg_eff;
    logic                        w_unused_stall;

    logic                        r_valid;
    logic [NUM_CH*ADDR_W-1:0]    r_wd;
    logic [NUM_CH-1:0]           r_wreg;
    logic [NUM_CH*DATA_W-1:0]    r_wdata;
    logic                        r_whilo;
    logic [DATA_W-1:0]           r_hi;
    logic [DATA_W-1:0]           r_lo;
    logic                        r_llbit_we;
    logic                        r_llbit_value;
    logic [31:0]                 r_retire_cnt;

    // Bits of the stall vector outside this stage's pair are deliberately ignored.
    assign w_unused_stall = ^stall;

    always_comb begin
        if (flush)
            w_action = ACT_FLUSH;
        else if (stall[STAGE_IDX] && !stall[STAGE_IDX+1])
            w_action = ACT_BUBBLE;
        else if (stall[STAGE_IDX+1])
            w_action = ACT_HOLD;
        else
            w_action = ACT_LOAD;
    end

    assign w_take = (w_action == ACT_LOAD) && mem_valid;

    // Writes to r0 are dropped; of two channels hitting the same register, the higher index wins.
    always_comb begin
        // NOTE: every variable gets a default before the loops so no latch can be inferred.
        w_wreg_base = '0;
        w_wreg_eff  = '0;
        for (int j = 0; j < NUM_CH; j++)
            w_wreg_base[j] = mem_wreg[j] && (mem_wd[j*ADDR_W +: ADDR_W] != '0);
        w_wreg_eff = w_wreg_base;
        for (int i = 0; i < NUM_CH; i++)
            for (int j = i + 1; j < NUM_CH; j++)
                if (w_wreg_base[i] && w_wreg_base[j] &&
                    (mem_wd[i*ADDR_W +: ADDR_W] == mem_wd[j*ADDR_W +: ADDR_W]))
                    w_wreg_eff[i] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid       <= 1'b0;
            r_wd          <= '0;
            r_wreg        <= '0;
            r_wdata       <= '0;
            r_whilo       <= 1'b0;
            r_hi          <= '0;
            r_lo          <= '0;
            r_llbit_we    <= 1'b0;
            r_llbit_value <= 1'b0;
            r_retire_cnt  <= '0;
        end else if (w_action != ACT_HOLD) begin
            if (w_take) begin
                r_valid       <= 1'b1;
                r_wd          <= mem_wd;
                r_wreg        <= w_wreg_eff;
                r_wdata       <= mem_wdata;
                r_whilo       <= (HILO_EN != 0) && mem_whilo;
                r_hi          <= (HILO_EN != 0) ? mem_hi : '0;
                r_lo          <= (HILO_EN != 0) ? mem_lo : '0;
                r_llbit_we    <= mem_llbit_we;
                r_llbit_value <= mem_llbit_value;
                r_retire_cnt  <= r_retire_cnt + 32'd1;
            end else begin
                // Flush, bubble, or a load of an empty slot all capture a bubble.
                r_valid       <= 1'b0;
                r_wd          <= '0;
                r_wreg        <= '0;
                r_wdata       <= '0;
                r_whilo       <= 1'b0;
                r_hi          <= '0;
                r_lo          <= '0;
                r_llbit_we    <= 1'b0;
                r_llbit_value <= 1'b0;
            end
        end
    end

    assign wb_valid       = r_valid;
    assign wb_wd          = r_wd;
    assign wb_wreg        = r_wreg;
    assign wb_wdata       = r_wdata;
    assign wb_whilo       = r_whilo;
    assign wb_hi          = r_hi;
    assign wb_lo          = r_lo;
    assign wb_llbit_we    = r_llbit_we;
    assign wb_llbit_value = r_llbit_value;
    assign retire_cnt     = r_retire_cnt;

endmodule

// File: tb/tb_mem_wb_pipe.sv
// Directed bench for mem_wb_pipe: two channels, one instance with HI/LO and one without.
module tb_mem_wb_pipe;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NC = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [5:0]        stall = '0;
    logic              flush = 1'b0;
    logic              mem_valid = 1'b0;
    logic [NC*AW-1:0]  mem_wd = '0;
    logic [NC-1:0]     mem_wreg = '0;
    logic [NC*DW-1:0]  mem_wdata = '0;
    logic              mem_whilo = 1'b0;
    logic [DW-1:0]     mem_hi = '0;
    logic [DW-1:0]     mem_lo = '0;
    logic              mem_llbit_we = 1'b0;
    logic              mem_llbit_value = 1'b0;

    logic              wb_valid, nh_valid;
    logic [NC*AW-1:0]  wb_wd, nh_wd;
    logic [NC-1:0]     wb_wreg, nh_wreg;
    logic [NC*DW-1:0]  wb_wdata, nh_wdata;
    logic              wb_whilo, nh_whilo;
    logic [DW-1:0]     wb_hi, wb_lo, nh_hi, nh_lo;
    logic              wb_llbit_we, wb_llbit_value, nh_llbit_we, nh_llbit_value;
    logic [31:0]       retire_cnt, nh_retire_cnt;

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    mem_wb_pipe #(.DATA_W(DW), .ADDR_W(AW), .NUM_CH(NC), .HILO_EN(1), .STAGE_IDX(3)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .mem_valid(mem_valid),
        .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
        .mem_whilo(mem_whilo), .mem_hi(mem_hi), .mem_lo(mem_lo),
        .mem_llbit_we(mem_llbit_we), .mem_llbit_value(mem_llbit_value),
        .wb_valid(wb_valid), .wb_wd(wb_wd), .wb_wreg(wb_wreg), .wb_wdata(wb_wdata),
        .wb_whilo(wb_whilo), .wb_hi(wb_hi), .wb_lo(wb_lo),
        .wb_llbit_we(wb_llbit_we), .wb_llbit_value(wb_llbit_value),
        .retire_cnt(retire_cnt)
    );

    mem_wb_pipe #(.DATA_W(DW), .ADDR_W(AW), .NUM_CH(NC), .HILO_EN(0), .STAGE_IDX(3)) dut_nh (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .mem_valid(mem_valid),
        .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
        .mem_whilo(mem_whilo), .mem_hi(mem_hi), .mem_lo(mem_lo),
        .mem_llbit_we(mem_llbit_we), .mem_llbit_value(mem_llbit_value),
        .wb_valid(nh_valid), .wb_wd(nh_wd), .wb_wreg(nh_wreg), .wb_wdata(nh_wdata),
        .wb_whilo(nh_whilo), .wb_hi(nh_hi), .wb_lo(nh_lo),
        .wb_llbit_we(nh_llbit_we), .wb_llbit_value(nh_llbit_value),
        .retire_cnt(nh_retire_cnt)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [4:0] wd1, input logic [4:0] wd0,
                         input logic [1:0] we, input logic [31:0] d1, input logic [31:0] d0);
        mem_valid = v;
        mem_wd    = {wd1, wd0};
        mem_wreg  = we;
        mem_wdata = {d1, d0};
    endtask

    task automatic check_empty(input string tag, input logic [31:0] cnt);
        check({tag, " valid"},  wb_valid, 0);
        check({tag, " wd"},     wb_wd, 0);
        check({tag, " wreg"},   wb_wreg, 0);
        check({tag, " wdata"},  wb_wdata, 0);
        check({tag, " hilo"},   {wb_whilo, wb_hi, wb_lo}, 0);
        check({tag, " llbit"},  {wb_llbit_we, wb_llbit_value}, 0);
        check({tag, " retire"}, retire_cnt, cnt);
    endtask

    initial begin
        // Reset state
        #2;
        check_empty("rst0", 0);
        check("rst0 nh retire", nh_retire_cnt, 0);
        @(negedge clk);
        rst = 1'b1;

        // T2: plain two-channel load with HI/LO and LLbit
        drive(1, 5'd7, 5'd3, 2'b11, 32'h22, 32'h11);
        mem_whilo = 1; mem_hi = 32'hDEAD; mem_lo = 32'hBEEF;
        mem_llbit_we = 1; mem_llbit_value = 1;
        step();
        check("t2 valid",  wb_valid, 1);
        check("t2 wreg",   wb_wreg, 2'b11);
        check("t2 wd",     wb_wd, {5'd7, 5'd3});
        check("t2 wdata",  wb_wdata, {32'h22, 32'h11});
        check("t2 hilo",   {wb_whilo, wb_hi, wb_lo}, {1'b1, 32'hDEAD, 32'hBEEF});
        check("t2 llbit",  {wb_llbit_we, wb_llbit_value}, 2'b11);
        check("t2 retire", retire_cnt, 1);
        check("t5 nohilo", {nh_whilo, nh_hi, nh_lo}, 0);
        check("t2 nh wdata", nh_wdata, {32'h22, 32'h11});

        // T3: hold keeps the entry even though the inputs change, then a bubble
        stall = 6'b011111;
        drive(1, 5'd4, 5'd6, 2'b11, 32'h44, 32'h33);
        step();
        check("t3 hold valid",  wb_valid, 1);
        check("t3 hold wdata",  wb_wdata, {32'h22, 32'h11});
        check("t3 hold wd",     wb_wd, {5'd7, 5'd3});
        check("t3 hold wreg",   wb_wreg, 2'b11);
        check("t3 hold retire", retire_cnt, 1);
        stall = 6'b001111;
        step();
        check_empty("t3 bubble", 1);

        // T4: reload, then flush beats hold
        stall = 6'b000000;
        step();
        check("t4 load wdata",  wb_wdata, {32'h44, 32'h33});
        check("t4 load retire", retire_cnt, 2);
        flush = 1; stall = 6'b111111;
        step();
        check_empty("t4 flush", 2);
        flush = 0; stall = 6'b000000;
        mem_whilo = 0; mem_hi = 0; mem_lo = 0; mem_llbit_we = 0; mem_llbit_value = 0;

        // T5: same-address conflict, r0 writes, and an invalid slot with enables set
        drive(1, 5'd9, 5'd9, 2'b11, 32'hB, 32'hA);
        step();
        check("t5 conflict wreg", wb_wreg, 2'b10);
        check("t5 conflict wd",   wb_wd, {5'd9, 5'd9});
        check("t5 conflict data", wb_wdata, {32'hB, 32'hA});
        check("t5 conflict ret",  retire_cnt, 3);
        drive(1, 5'd5, 5'd0, 2'b11, 32'hD, 32'hC);
        step();
        check("t5 zero0 wreg", wb_wreg, 2'b10);
        check("t5 zero0 wd",   wb_wd, {5'd5, 5'd0});
        check("t5 zero0 data", wb_wdata, {32'hD, 32'hC});
        drive(1, 5'd0, 5'd5, 2'b11, 32'hF, 32'hE);
        step();
        check("t5 zero1 wreg", wb_wreg, 2'b01);
        check("t5 zero1 ret",  retire_cnt, 5);
        drive(1, 5'd2, 5'd1, 2'b01, 32'h2, 32'h1);
        step();
        check("t5 ch0only wreg", wb_wreg, 2'b01);
        drive(0, 5'd2, 5'd1, 2'b11, 32'h2, 32'h1);
        mem_llbit_we = 1;
        step();
        check_empty("t5 invalid", 6);
        mem_llbit_we = 0;

        // T1: reset asserted mid-cycle with a hold pending; released later under hold
        drive(1, 5'd8, 5'd6, 2'b11, 32'h66, 32'h55);
        step();
        check("t1 preload valid", wb_valid, 1);
        stall = 6'b011111;
        #2;
        rst = 1'b0;
        #1;
        check_empty("t1 async", 0);
        check("t1 nh retire", nh_retire_cnt, 0);
        @(negedge clk);
        rst = 1'b1;
        step();
        check_empty("t1 hold after rst", 0);
        stall = 6'b000000;
        step();
        check("t1 first load wdata",  wb_wdata, {32'h66, 32'h55});
        check("t1 first load retire", retire_cnt, 1);

        // T6: counter wrap
        @(negedge clk);
        force dut.r_retire_cnt = 32'hFFFF_FFFE;
        #1;
        release dut.r_retire_cnt;
        step();
        check("t6 wrap max",  retire_cnt, 32'hFFFF_FFFF);
        step();
        check("t6 wrap zero", retire_cnt, 32'h0000_0000);
        step();
        check("t6 after wrap", retire_cnt, 32'h0000_0001);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
